div_seq_param: RTL and testbench
================================

// Module: div_seq_param
// PURPOSE
//  Parametrised multi-cycle restoring divider for the MIPS EX stage (DIV/DIVU -> HI/LO).
//  Computes quotient and remainder of WIDTH-bit operands, signed or unsigned, one bit/cycle.
//  Adds a busy flag, a divide-by-zero flag and correct sign fix-up for quotient and remainder.
//  Supports an optional early-out fast path.
// PARAMETERS
//  WIDTH    32                  operand width; legal values >= 2
//  CNT_W    $clog2(WIDTH+1)     localparam; width of the iteration counter
// PORTS
//  clk            in   1        clock; all logic on posedge
//  rst            in   1        asynchronous, active-high reset
//  signed_div_in  in   1        1 = two's-complement operands, 0 = unsigned
//  dived_in       in   WIDTH    dividend; sampled at accept
//  div_in         in   WIDTH    divisor; sampled at accept
//  div_start_in   in   1        request; accepted only in IDLE or DONE
//  div_cancel_in  in   1        abort the operation in flight
//  div_busy_out   out  1        high in RUN and FIX
//  div_ready_out  out  1        one-cycle pulse: result valid
//  div_res_out    out  2*WIDTH  {remainder, quotient}; held until the next ready pulse
//  div_zero_out   out  1        divisor was 0; valid with div_res_out, held with it
// BEHAVIOUR
//  - Reset: state=IDLE; div_busy_out=0, div_ready_out=0, div_res_out=0, div_zero_out=0.
//  - Operands and signed_div_in are latched at accept; later input changes have no effect.
//  - Accept condition: (IDLE|DONE) & div_start_in & !div_cancel_in.
//  - Magnitudes: |x| = (signed & x[MSB]) ? -x : x, held in WIDTH bits as unsigned
//    (|MIN| = 2^(WIDTH-1)).
//  - States and transitions:
//    - IDLE: on accept, divisor==0 -> FIX; otherwise -> RUN with cnt=0.
//    - RUN: one restoring step per cycle on a {rem, quo} shift register, using a
//      (WIDTH+1)-bit trial subtract. When cnt==WIDTH-1 -> FIX.
//    - FIX: apply sign correction.
//      - Negate the quotient if signed & (dividend MSB ^ divisor MSB).
//      - Negate the remainder if signed & dividend MSB (remainder takes the dividend's sign).
//      - Then load div_res_out and div_zero_out -> DONE.
//    - DONE: div_ready_out=1 for this cycle only -> IDLE, or a new accept.
//  - Latency: div_ready_out is high in the cycle after edge N, counting the accept edge as edge 0.
//    - Normal operation: N = WIDTH+1 (33 for WIDTH=32).
//    - Divisor zero: N = 1.
//  - Divide by zero: quotient = all ones; remainder = dividend, raw; div_zero_out=1.
//  - Signed MIN / -1: quotient = MIN, remainder = 0. No trap; overflow wraps.
//  - Rounding: the quotient truncates toward zero. Both results satisfy q*d + r == dividend (mod 2^WIDTH).
//  - Cancel in RUN or FIX: -> IDLE at the next edge. No ready pulse.
//    div_res_out and div_zero_out keep their previous values.
//  - Cancel in IDLE or DONE: blocks the accept for that cycle; the DONE pulse still completes.
//  - div_start_in while busy: ignored; no queueing.
//  - Async reset mid-operation: immediate return to IDLE; all outputs return to their reset values.
// CONFIGURATION
//  DIV_EARLY_OUT_EN
//    - Defined: at accept, if the divisor is non-zero and |dividend| < |divisor|, -> FIX directly
//      with quotient 0 and remainder = |dividend|, then signed fix-up as usual.
//      Latency N = 1.
//    - Undefined: no fast path; always WIDTH RUN cycles. Results are identical either way;
//      only the latency differs.
// TESTING
//  1. Unsigned, WIDTH=32: 100 / 7 -> q=14, r=2, zero=0; ready exactly 33 edges after accept,
//     1 cycle wide.
//  2. Signed: -7 / 2 -> q=-3 (FFFFFFFD), r=-1 (FFFFFFFF); 7 / -2 -> q=-3, r=1.
//  3. Signed 80000000 / FFFFFFFF -> q=80000000, r=0. Unsigned, same operands -> q=0, r=80000000.
//  4. 1234 / 0 -> ready at N=1, zero=1, q=FFFFFFFF, r=1234. Next normal divide -> zero=0.
//  5. Cancel at RUN cycle 10 -> busy drops next cycle, no ready, div_res_out unchanged.
//     A start 5 cycles after accept is ignored.
//  6. DIV_EARLY_OUT_EN: 3 / 10 -> q=0, r=3 at N=1. Without the macro, N=33 and the same result.
//     Also repeat scenario 1 with WIDTH=8 and WIDTH=64.

Source files
------------

// File: rtl/div_seq_param.sv
// div_seq_param
//   Multi-cycle restoring divider (one quotient bit per clock) for the MIPS
//   EX stage DIV/DIVU path. Handles signed and unsigned operands, divide by
//   zero, and the sign fix-up of quotient and remainder.
//
//   Ports
//     clk            clock, all logic on posedge
//     rst            asynchronous active-high reset
//     signed_div_in  1 = two's-complement operands, 0 = unsigned
//     dived_in       dividend, sampled at accept
//     div_in         divisor, sampled at accept
//     div_start_in   request, accepted in IDLE or DONE
//     div_cancel_in  abort the operation in flight / block an accept
//     div_busy_out   high while in RUN and FIX
//     div_ready_out  one-cycle pulse when div_res_out is updated
//     div_res_out    {remainder, quotient}, held until the next ready pulse
//     div_zero_out   divisor was zero, held with div_res_out
//
//   Optional feature macro: DIV_EARLY_OUT_EN
//     When defined, an accept with |dividend| < |divisor| skips RUN and goes
//     straight to FIX. Results are identical; only latency changes.
//
//   state | meaning
//   IDLE  | waiting for a request
//   RUN   | one restoring step per cycle, WIDTH cycles
//   FIX   | sign correction, load outputs
//   DONE  | ready pulse; may accept a new request

module div_seq_param #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_in,
    input  logic [WIDTH-1:0]   dived_in,
    input  logic [WIDTH-1:0]   div_in,
    input  logic               div_start_in,
    input  logic               div_cancel_in,
    output logic               div_busy_out,
    output logic               div_ready_out,
    output logic [2*WIDTH-1:0] div_res_out,
    output logic               div_zero_out
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs_mag;
    logic             neg_quo;
    logic             neg_rem;
    logic             zero_op;

    logic             accept;
    logic [WIDTH-1:0] dived_mag;
    logic [WIDTH-1:0] div_mag;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;
    logic             early;

    always_comb begin
        accept    = ((state == S_IDLE) || (state == S_DONE)) && div_start_in && !div_cancel_in;
        // |MIN| comes out as 2^(WIDTH-1), which is exact when read as unsigned
        dived_mag = (signed_div_in && dived_in[WIDTH-1]) ? -dived_in : dived_in;
        div_mag   = (signed_div_in && div_in[WIDTH-1])   ? -div_in   : div_in;
        // next partial remainder bit comes from the top of the quotient register
        rem_shift = {rem, quo[WIDTH-1]};
        trial     = rem_shift - {1'b0, dvs_mag};
        quo_fix   = neg_quo ? -quo : quo;
        rem_fix   = neg_rem ? -rem : rem;
    end

`ifdef DIV_EARLY_OUT_EN
    assign early = (dived_mag < div_mag);
`else
    assign early = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            cnt           <= '0;
            rem           <= '0;
            quo           <= '0;
            dvs_mag       <= '0;
            neg_quo       <= 1'b0;
            neg_rem       <= 1'b0;
            zero_op       <= 1'b0;
            div_busy_out  <= 1'b0;
            div_ready_out <= 1'b0;
            div_res_out   <= '0;
            div_zero_out  <= 1'b0;
        end else begin
            div_ready_out <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        dvs_mag      <= div_mag;
                        neg_quo      <= signed_div_in & (dived_in[WIDTH-1] ^ div_in[WIDTH-1]);
                        neg_rem      <= signed_div_in & dived_in[WIDTH-1];
                        cnt          <= '0;
                        div_busy_out <= 1'b1;
                        if (div_in == '0) begin
                            // raw dividend and all-ones quotient bypass the sign fix-up
                            zero_op <= 1'b1;
                            rem     <= dived_in;
                            quo     <= '1;
                            state   <= S_FIX;
                        end else if (early) begin
                            zero_op <= 1'b0;
                            rem     <= dived_mag;
                            quo     <= '0;
                            state   <= S_FIX;
                        end else begin
                            zero_op <= 1'b0;
                            rem     <= '0;
                            quo     <= dived_mag;
                            state   <= S_RUN;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end

                S_RUN: begin
                    if (div_cancel_in) begin
                        div_busy_out <= 1'b0;
                        state        <= S_IDLE;
                    end else begin
                        if (!trial[WIDTH]) begin
                            rem <= trial[WIDTH-1:0];
                            quo <= {quo[WIDTH-2:0], 1'b1};
                        end else begin
                            rem <= rem_shift[WIDTH-1:0];
                            quo <= {quo[WIDTH-2:0], 1'b0};
                        end
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST_CNT) begin
                            state <= S_FIX;
                        end
                    end
                end

                S_FIX: begin
                    div_busy_out <= 1'b0;
                    if (div_cancel_in) begin
                        state <= S_IDLE;
                    end else begin
                        div_res_out   <= zero_op ? {rem, quo} : {rem_fix, quo_fix};
                        div_zero_out  <= zero_op;
                        div_ready_out <= 1'b1;
                        state         <= S_DONE;
                    end
                end

                default: begin
                    div_busy_out <= 1'b0;
                    state        <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq_param.sv
module tb_div_seq_param;

    localparam int LAT_NORM = 33;
`ifdef DIV_EARLY_OUT_EN
    localparam int LAT_SMALL = 1;
`else
    localparam int LAT_SMALL = 33;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        sg, start, cancel;
    logic [31:0] a, b;
    logic        busy, ready, zero;
    logic [63:0] res;

    logic        sg8, st8, busy8, rdy8, z8;
    logic [7:0]  a8, b8;
    logic [15:0] res8;
    logic        sg64, st64, busy64, rdy64, z64;
    logic [63:0] a64, b64;
    logic [127:0] res64;
    logic        cancel_w;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    div_seq_param #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .signed_div_in(sg), .dived_in(a), .div_in(b),
        .div_start_in(start), .div_cancel_in(cancel), .div_busy_out(busy),
        .div_ready_out(ready), .div_res_out(res), .div_zero_out(zero)
    );

    div_seq_param #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .signed_div_in(sg8), .dived_in(a8), .div_in(b8),
        .div_start_in(st8), .div_cancel_in(cancel_w), .div_busy_out(busy8),
        .div_ready_out(rdy8), .div_res_out(res8), .div_zero_out(z8)
    );

    div_seq_param #(.WIDTH(64)) dut64 (
        .clk(clk), .rst(rst), .signed_div_in(sg64), .dived_in(a64), .div_in(b64),
        .div_start_in(st64), .div_cancel_in(cancel_w), .div_busy_out(busy64),
        .div_ready_out(rdy64), .div_res_out(res64), .div_zero_out(z64)
    );

    // Launch one divide on the 32-bit instance and wait for its ready pulse.
    // lat is the edge count after the accept edge; -1 means no pulse seen.
    // poke > 0 raises start with junk operands before that edge while busy.
    task automatic run_div(input bit now, input logic sgn, input logic [31:0] dd,
                           input logic [31:0] dv, input int poke,
                           output logic [63:0] r, output logic z, output int lat);
        if (!now) @(negedge clk);
        sg = sgn; a = dd; b = dv; start = 1'b1;
        @(posedge clk);
        lat = -1; r = '0; z = 1'b0;
        for (int k = 0; k <= 200 && lat < 0; k++) begin
            @(negedge clk);
            if (k > 0 && ready === 1'b1) begin
                lat = k; r = res; z = zero;
            end else begin
                start = (k + 1 == poke);
                a = $urandom; b = $urandom; sg = 1'($urandom_range(0, 1));
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; sg = 0; a = 0; b = 0; start = 0; cancel = 0;
        sg8 = 0; a8 = 0; b8 = 0; st8 = 0; sg64 = 0; a64 = 0; b64 = 0; st64 = 0; cancel_w = 0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", ready); end
        checks++; if (res !== 64'h0) begin errors++; $display("FAIL reset_res: got %h expected 0", res); end
        checks++; if (zero !== 1'b0) begin errors++; $display("FAIL reset_zero: got %b expected 0", zero); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_unsigned();
        logic [63:0] r; logic z; int lat;
        run_div(0, 1'b0, 32'd100, 32'd7, 0, r, z, lat);
        checks++; if (r !== {32'd2, 32'd14}) begin errors++; $display("FAIL u100_7_res: got %h expected %h", r, {32'd2, 32'd14}); end
        checks++; if (z !== 1'b0) begin errors++; $display("FAIL u100_7_zero: got %b expected 0", z); end
        checks++; if (lat != LAT_NORM) begin errors++; $display("FAIL u100_7_lat: got %0d expected %0d", lat, LAT_NORM); end
        @(negedge clk);
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL u100_7_pulse_width: got %b expected 0", ready); end
        run_div(0, 1'b0, 32'hFFFF_FFFF, 32'h10, 0, r, z, lat);
        checks++; if (r !== {32'hF, 32'h0FFF_FFFF}) begin errors++; $display("FAIL uffff_16_res: got %h expected %h", r, {32'hF, 32'h0FFF_FFFF}); end
        checks++; if (lat != LAT_NORM) begin errors++; $display("FAIL uffff_16_lat: got %0d expected %0d", lat, LAT_NORM); end
    endtask

    task automatic test_signed();
        logic [63:0] r; logic z; int lat;
        run_div(0, 1'b1, 32'hFFFF_FFF9, 32'd2, 0, r, z, lat);
        checks++; if (r !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin errors++; $display("FAIL s_m7_2_res: got %h expected %h", r, {32'hFFFF_FFFF, 32'hFFFF_FFFD}); end
        checks++; if (lat != LAT_NORM) begin errors++; $display("FAIL s_m7_2_lat: got %0d expected %0d", lat, LAT_NORM); end
        run_div(0, 1'b1, 32'd7, 32'hFFFF_FFFE, 0, r, z, lat);
        checks++; if (r !== {32'd1, 32'hFFFF_FFFD}) begin errors++; $display("FAIL s_7_m2_res: got %h expected %h", r, {32'd1, 32'hFFFF_FFFD}); end
    endtask

    task automatic test_min_neg1();
        logic [63:0] r; logic z; int lat;
        run_div(0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, r, z, lat);
        checks++; if (r !== {32'h0, 32'h8000_0000}) begin errors++; $display("FAIL s_min_m1_res: got %h expected %h", r, {32'h0, 32'h8000_0000}); end
        run_div(0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0, r, z, lat);
        checks++; if (r !== {32'h8000_0000, 32'h0}) begin errors++; $display("FAIL u_min_m1_res: got %h expected %h", r, {32'h8000_0000, 32'h0}); end
        checks++; if (lat != LAT_SMALL) begin errors++; $display("FAIL u_min_m1_lat: got %0d expected %0d", lat, LAT_SMALL); end
    endtask

    task automatic test_div_zero();
        logic [63:0] r; logic z; int lat;
        run_div(0, 1'b0, 32'd1234, 32'd0, 0, r, z, lat);
        checks++; if (r !== {32'd1234, 32'hFFFF_FFFF}) begin errors++; $display("FAIL dz_res: got %h expected %h", r, {32'd1234, 32'hFFFF_FFFF}); end
        checks++; if (z !== 1'b1) begin errors++; $display("FAIL dz_zero: got %b expected 1", z); end
        checks++; if (lat != 1) begin errors++; $display("FAIL dz_lat: got %0d expected 1", lat); end
        run_div(0, 1'b0, 32'd100, 32'd7, 0, r, z, lat);
        checks++; if (z !== 1'b0) begin errors++; $display("FAIL dz_next_zero: got %b expected 0", z); end
        checks++; if (r !== {32'd2, 32'd14}) begin errors++; $display("FAIL dz_next_res: got %h expected %h", r, {32'd2, 32'd14}); end
        run_div(0, 1'b1, 32'hFFFF_FFFB, 32'd0, 0, r, z, lat);
        checks++; if (r !== {32'hFFFF_FFFB, 32'hFFFF_FFFF}) begin errors++; $display("FAIL dz_signed_res: got %h expected %h", r, {32'hFFFF_FFFB, 32'hFFFF_FFFF}); end
        checks++; if (z !== 1'b1) begin errors++; $display("FAIL dz_signed_zero: got %b expected 1", z); end
    endtask

    task automatic test_start_while_busy();
        logic [63:0] r; logic z; int lat;
        run_div(0, 1'b0, 32'd100, 32'd7, 5, r, z, lat);
        checks++; if (r !== {32'd2, 32'd14}) begin errors++; $display("FAIL busy_start_res: got %h expected %h", r, {32'd2, 32'd14}); end
        checks++; if (lat != LAT_NORM) begin errors++; $display("FAIL busy_start_lat: got %0d expected %0d", lat, LAT_NORM); end
    endtask

    task automatic test_cancel();
        logic [63:0] r; logic z; int lat; bit seen;
        run_div(0, 1'b0, 32'd1234, 32'd0, 0, r, z, lat);
        @(negedge clk);
        sg = 1'b0; a = 32'd5000; b = 32'd3; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL cancel_busy_before: got %b expected 1", busy); end
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cancel_busy_after: got %b expected 0", busy); end
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (ready === 1'b1) seen = 1;
        end
        checks++; if (seen) begin errors++; $display("FAIL cancel_no_ready: got 1 expected 0"); end
        checks++; if (res !== {32'd1234, 32'hFFFF_FFFF}) begin errors++; $display("FAIL cancel_res_held: got %h expected %h", res, {32'd1234, 32'hFFFF_FFFF}); end
        checks++; if (zero !== 1'b1) begin errors++; $display("FAIL cancel_zero_held: got %b expected 1", zero); end
        // cancel together with start in IDLE blocks the accept
        a = 32'd100; b = 32'd7; start = 1'b1; cancel = 1'b1;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cancel_idle_block: got %b expected 0", busy); end
    endtask

    task automatic test_early_out();
        logic [63:0] r; logic z; int lat;
        run_div(0, 1'b0, 32'd3, 32'd10, 0, r, z, lat);
        checks++; if (r !== {32'd3, 32'd0}) begin errors++; $display("FAIL eo_3_10_res: got %h expected %h", r, {32'd3, 32'd0}); end
        checks++; if (lat != LAT_SMALL) begin errors++; $display("FAIL eo_3_10_lat: got %0d expected %0d", lat, LAT_SMALL); end
        run_div(0, 1'b1, 32'hFFFF_FFFD, 32'd10, 0, r, z, lat);
        checks++; if (r !== {32'hFFFF_FFFD, 32'd0}) begin errors++; $display("FAIL eo_m3_10_res: got %h expected %h", r, {32'hFFFF_FFFD, 32'd0}); end
        checks++; if (lat != LAT_SMALL) begin errors++; $display("FAIL eo_m3_10_lat: got %0d expected %0d", lat, LAT_SMALL); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] r; logic z; int lat;
        run_div(0, 1'b0, 32'd100, 32'd7, 0, r, z, lat);
        checks++; if (r !== {32'd2, 32'd14}) begin errors++; $display("FAIL b2b_first_res: got %h expected %h", r, {32'd2, 32'd14}); end
        run_div(1, 1'b0, 32'd50, 32'd5, 0, r, z, lat);
        checks++; if (r !== {32'd0, 32'd10}) begin errors++; $display("FAIL b2b_second_res: got %h expected %h", r, {32'd0, 32'd10}); end
        checks++; if (lat != LAT_NORM) begin errors++; $display("FAIL b2b_second_lat: got %0d expected %0d", lat, LAT_NORM); end
    endtask

    task automatic test_widths();
        int lat8, lat64;
        logic [15:0] r8;
        logic [127:0] r64;
        @(negedge clk);
        sg8 = 0; a8 = 8'd100; b8 = 8'd7; st8 = 1'b1;
        sg64 = 0; a64 = 64'd100; b64 = 64'd7; st64 = 1'b1;
        @(posedge clk);
        lat8 = -1; lat64 = -1; r8 = '0; r64 = '0;
        for (int k = 0; k <= 100; k++) begin
            @(negedge clk);
            st8 = 1'b0; st64 = 1'b0;
            if (k > 0 && rdy8 === 1'b1 && lat8 < 0) begin lat8 = k; r8 = res8; end
            if (k > 0 && rdy64 === 1'b1 && lat64 < 0) begin lat64 = k; r64 = res64; end
        end
        checks++; if (r8 !== {8'd2, 8'd14}) begin errors++; $display("FAIL w8_res: got %h expected %h", r8, {8'd2, 8'd14}); end
        checks++; if (lat8 != 9) begin errors++; $display("FAIL w8_lat: got %0d expected 9", lat8); end
        checks++; if (r64 !== {64'd2, 64'd14}) begin errors++; $display("FAIL w64_res: got %h expected %h", r64, {64'd2, 64'd14}); end
        checks++; if (lat64 != 65) begin errors++; $display("FAIL w64_lat: got %0d expected 65", lat64); end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        sg = 1'b0; a = 32'd100; b = 32'd7; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL arst_busy_before: got %b expected 1", busy); end
        checks++; if (res === 64'h0) begin errors++; $display("FAIL arst_res_before: got %h expected nonzero", res); end
        #2 rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_busy: got %b expected 0", busy); end
        checks++; if (res !== 64'h0) begin errors++; $display("FAIL arst_res: got %h expected 0", res); end
        checks++; if (zero !== 1'b0) begin errors++; $display("FAIL arst_zero: got %b expected 0", zero); end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_min_neg1();
        test_div_zero();
        test_start_while_busy();
        test_cancel();
        test_early_out();
        test_back_to_back();
        test_widths();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
